// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: effective address, byte-lane steering, load extension.
// Latency: accept -> REQ next cycle; DONE one cycle after the DM_ACK edge (2 cycles min).
// Backpressure: STALL high whenever not IDLE; DM_* held stable until DM_ACK.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   VALID, IS_LOAD, B_HW_W,       decoded transfer request (sampled in IDLE only)
//   SIGNED, UP, PRE, WB,
//   BASE, OFFSET, STORE_DATA
//   DM_REQ/WE/ADDR/BE/WDATA,      data-memory req/ack port
//   DM_ACK, DM_RDATA
//   LOAD_DATA, DONE, LOAD_VALID,  completion results and base writeback
//   WB_VALID, WB_ADDR
//   MISALIGN, STALL               fault pulse, pipeline stall
module mem_access_unit #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALID,
  input  logic              IS_LOAD,
  input  logic [1:0]        B_HW_W,
  input  logic              SIGNED,
  input  logic              UP,
  input  logic              PRE,
  input  logic              WB,
  input  logic [DATA_W-1:0] BASE,
  input  logic [DATA_W-1:0] OFFSET,
  input  logic [DATA_W-1:0] STORE_DATA,
  input  logic              DM_ACK,
  input  logic [DATA_W-1:0] DM_RDATA,
  output logic              DM_REQ,
  output logic              DM_WE,
  output logic [DATA_W-1:0] DM_ADDR,
  output logic [3:0]        DM_BE,
  output logic [DATA_W-1:0] DM_WDATA,
  output logic [DATA_W-1:0] LOAD_DATA,
  output logic              DONE,
  output logic              LOAD_VALID,
  output logic              WB_VALID,
  output logic [DATA_W-1:0] WB_ADDR,
  output logic              MISALIGN,
  output logic              STALL
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  state_t            state;
  logic              is_load_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              wbv_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] eff_q;

  logic [DATA_W-1:0] eff_c;
  logic [DATA_W-1:0] addr_c;
  logic              is_byte_c;
  logic              is_half_c;
  logic              mis_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] ext_c;

  // Address generation and lane steering for the request being offered in IDLE.
  always_comb begin
    eff_c     = UP ? (BASE + OFFSET) : (BASE - OFFSET);
    addr_c    = PRE ? eff_c : BASE;
    is_byte_c = (B_HW_W == 2'b10);
    is_half_c = (B_HW_W == 2'b01);
    // 2'b00 and 2'b11 both behave as word accesses
    mis_c     = is_half_c ? addr_c[0] : (!is_byte_c && (addr_c[1:0] != 2'b00));
    if (is_byte_c) begin
      be_c    = 4'b0001 << addr_c[1:0];
      wdata_c = {4{STORE_DATA[7:0]}};
    end else if (is_half_c) begin
      be_c    = addr_c[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{STORE_DATA[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = STORE_DATA;
    end
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_c = DM_RDATA >> {lane_q, 3'b000};
    case (size_q)
      2'b10:   ext_c = {{24{sgn_q & shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ext_c = {{16{sgn_q & shifted_c[15]}}, shifted_c[15:0]};
      default: ext_c = DM_RDATA;
    endcase
  end

  assign STALL = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      is_load_q  <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      wbv_q      <= 1'b0;
      lane_q     <= 2'b00;
      eff_q      <= '0;
      DM_REQ     <= 1'b0;
      DM_WE      <= 1'b0;
      DM_ADDR    <= '0;
      DM_BE      <= 4'b0000;
      DM_WDATA   <= '0;
      LOAD_DATA  <= '0;
      DONE       <= 1'b0;
      LOAD_VALID <= 1'b0;
      WB_VALID   <= 1'b0;
      WB_ADDR    <= '0;
      MISALIGN   <= 1'b0;
    end else begin
      // completion/fault strobes are single-cycle pulses
      DONE       <= 1'b0;
      LOAD_VALID <= 1'b0;
      WB_VALID   <= 1'b0;
      MISALIGN   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (VALID) begin
            is_load_q <= IS_LOAD;
            size_q    <= B_HW_W;
            sgn_q     <= SIGNED;
            wbv_q     <= WB | !PRE;  // post-index always updates the base
            lane_q    <= addr_c[1:0];
            eff_q     <= eff_c;
            if (mis_c) begin
              MISALIGN <= 1'b1;
              state    <= S_FAULT;
            end else begin
              DM_REQ   <= 1'b1;
              DM_WE    <= !IS_LOAD;
              DM_ADDR  <= {addr_c[DATA_W-1:2], 2'b00};
              DM_BE    <= be_c;
              DM_WDATA <= wdata_c;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (DM_ACK) begin
            DM_REQ     <= 1'b0;
            DM_WE      <= 1'b0;
            DONE       <= 1'b1;
            LOAD_VALID <= is_load_q;
            WB_VALID   <= wbv_q;
            WB_ADDR    <= eff_q;
            if (is_load_q) begin
              LOAD_DATA <= ext_c;
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: vector table applied by a driver, completions scored from a queue.
// Latency and DM_* stability checked per request cycle; reset abort and late ACK as a hand sequence.
// Memory model answers with a configurable number of REQ cycles before DM_ACK.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID;
  logic        IS_LOAD;
  logic [1:0]  B_HW_W;
  logic        SIGNED;
  logic        UP;
  logic        PRE;
  logic        WB;
  logic [31:0] BASE;
  logic [31:0] OFFSET;
  logic [31:0] STORE_DATA;
  logic        DM_ACK;
  logic [31:0] DM_RDATA;
  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [3:0]  DM_BE;
  logic [31:0] DM_WDATA;
  logic [31:0] LOAD_DATA;
  logic        DONE;
  logic        LOAD_VALID;
  logic        WB_VALID;
  logic [31:0] WB_ADDR;
  logic        MISALIGN;
  logic        STALL;

  mem_access_unit #(.DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .VALID(VALID), .IS_LOAD(IS_LOAD), .B_HW_W(B_HW_W),
    .SIGNED(SIGNED), .UP(UP), .PRE(PRE), .WB(WB), .BASE(BASE), .OFFSET(OFFSET),
    .STORE_DATA(STORE_DATA), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_BE(DM_BE),
    .DM_WDATA(DM_WDATA), .LOAD_DATA(LOAD_DATA), .DONE(DONE), .LOAD_VALID(LOAD_VALID),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .MISALIGN(MISALIGN), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        sg;
    logic        up;
    logic        pre;
    logic        wb;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sd;
    logic [31:0] rd;
    int          wt;      // REQ cycles until ACK (1 = zero-wait)
    logic        flt;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld_exp;
    logic        wbv;
    logic [31:0] wba;
  } vec_t;

  vec_t        vt[13];
  vec_t        sb[$];
  vec_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cur = -1;
  logic [31:0] last_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur, act, exp);
    end
  endtask

  // Completion scoreboard: every DONE or MISALIGN pulse retires the oldest request.
  always @(negedge CLK) begin
    if (RST === 1'b0 && (DONE === 1'b1 || MISALIGN === 1'b1)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: done=%b misalign=%b with nothing outstanding", DONE, MISALIGN);
      end else begin
        mon_e = sb.pop_front();
        check("misalign", {31'b0, MISALIGN}, {31'b0, mon_e.flt});
        check("done", {31'b0, DONE}, {31'b0, !mon_e.flt});
        check("load_valid", {31'b0, LOAD_VALID}, {31'b0, !mon_e.flt && mon_e.ld});
        check("wb_valid", {31'b0, WB_VALID}, {31'b0, !mon_e.flt && mon_e.wbv});
        if (!mon_e.flt) check("wb_addr", WB_ADDR, mon_e.wba);
        if (!mon_e.flt && mon_e.ld) last_load = mon_e.ld_exp;
        check("load_data", LOAD_DATA, last_load);
      end
    end
  end

  task automatic run(input vec_t v);
    @(negedge CLK);
    check("idle_stall", {31'b0, STALL}, 32'd0);
    IS_LOAD    = v.ld;
    B_HW_W     = v.sz;
    SIGNED     = v.sg;
    UP         = v.up;
    PRE        = v.pre;
    WB         = v.wb;
    BASE       = v.base;
    OFFSET     = v.off;
    STORE_DATA = v.sd;
    VALID      = 1'b1;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    // accepted: scramble request inputs so the DUT must rely on its registered copy
    VALID      = 1'b0;
    BASE       = $urandom;
    OFFSET     = $urandom;
    STORE_DATA = $urandom;
    PRE        = ~PRE;
    IS_LOAD    = ~IS_LOAD;
    B_HW_W     = ~B_HW_W;
    if (v.flt) begin
      @(negedge CLK);
      check("fault_no_req", {31'b0, DM_REQ}, 32'd0);
      check("fault_stall", {31'b0, STALL}, 32'd1);
    end else begin
      for (int c = 1; c <= v.wt; c++) begin
        @(negedge CLK);
        check("req", {31'b0, DM_REQ}, 32'd1);
        check("req_addr", DM_ADDR, v.addr);
        check("req_be", {28'b0, DM_BE}, {28'b0, v.be});
        check("req_wdata", DM_WDATA, v.wd);
        check("req_we", {31'b0, DM_WE}, {31'b0, !v.ld});
        if (c < v.wt) begin
          VALID = 1'b1;       // must be ignored while busy
        end else begin
          VALID    = 1'b0;
          DM_ACK   = 1'b1;
          DM_RDATA = v.rd;
        end
      end
      @(posedge CLK);
      #1;
      DM_ACK   = 1'b0;
      DM_RDATA = $urandom;
      @(negedge CLK);
      check("done_latency", {31'b0, DONE}, 32'd1);
      check("done_req_low", {31'b0, DM_REQ}, 32'd0);
      check("done_stall", {31'b0, STALL}, 32'd1);
    end
  endtask

  initial begin
    RST = 1'b1; VALID = 1'b0; IS_LOAD = 1'b0; B_HW_W = 2'b00; SIGNED = 1'b0;
    UP = 1'b0; PRE = 1'b0; WB = 1'b0; BASE = '0; OFFSET = '0; STORE_DATA = '0;
    DM_ACK = 1'b0; DM_RDATA = '0; last_load = '0;

    //        ld    sz     sg    up    pre   wb    base           off            sd             rd             wt flt   addr           be       wd             ld_exp         wbv   wba
    vt[0]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'h1122_3344, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0104, 4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1, 32'h0000_0104};
    vt[1]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0008, 32'h0000_0000, 32'h0BAD_F00D, 2, 1'b0, 32'h0000_0108, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0000_0108};
    vt[2]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1, 1'b0, 32'h0000_0200, 4'h8, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 32'h0000_0203};
    vt[3]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1, 1'b0, 32'h0000_0200, 4'h8, 32'h0000_0000, 32'h0000_0080, 1'b0, 32'h0000_0203};
    vt[4]  = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0002, 32'h1234_ABCD, 32'h0000_0000, 3, 1'b0, 32'h0000_0300, 4'hC, 32'hABCD_ABCD, 32'h0000_0000, 1'b1, 32'h0000_0302};
    vt[5]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0010, 32'h0000_0000, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_0400, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 32'h0000_03F0};
    vt[6]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vt[7]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0601, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vt[8]  = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0002, 32'h0000_0000, 32'h9ABC_1234, 1, 1'b0, 32'h0000_0700, 4'hC, 32'h0000_0000, 32'hFFFF_9ABC, 1'b0, 32'h0000_0702};
    vt[9]  = '{1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h0000_0001, 32'h0000_00A5, 32'h0000_0000, 2, 1'b0, 32'h0000_0800, 4'h2, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 32'h0000_0801};
    vt[10] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'h0000_0003, 32'h0000_0000, 32'h8000_0001, 1, 1'b0, 32'h0000_0900, 4'hF, 32'h0000_0000, 32'h8000_0001, 1'b1, 32'h0000_0903};
    vt[11] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0A04, 32'h0000_0002, 32'h0000_0000, 32'h00F7_0000, 1, 1'b0, 32'h0000_0A00, 4'h4, 32'h0000_0000, 32'h0000_00F7, 1'b0, 32'h0000_0A02};
    vt[12] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0000_0000, 32'h0000_0000, 32'h0000_F00F, 1, 1'b0, 32'h0000_0B00, 4'h3, 32'h0000_0000, 32'h0000_F00F, 1'b0, 32'h0000_0B00};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_dm_req", {31'b0, DM_REQ}, 32'd0);
    check("rst_dm_we", {31'b0, DM_WE}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    check("rst_load_valid", {31'b0, LOAD_VALID}, 32'd0);
    check("rst_wb_valid", {31'b0, WB_VALID}, 32'd0);
    check("rst_misalign", {31'b0, MISALIGN}, 32'd0);
    check("rst_stall", {31'b0, STALL}, 32'd0);
    check("rst_dm_addr", DM_ADDR, 32'd0);
    check("rst_dm_be", {28'b0, DM_BE}, 32'd0);
    check("rst_dm_wdata", DM_WDATA, 32'd0);
    check("rst_load_data", LOAD_DATA, 32'd0);
    check("rst_wb_addr", WB_ADDR, 32'd0);

    for (int i = 0; i < 13; i++) begin
      cur = i;
      run(vt[i]);
    end

    // reset while a request is outstanding, then a stray ACK
    cur = 100;
    @(negedge CLK);
    IS_LOAD = 1'b1; B_HW_W = 2'b00; SIGNED = 1'b0; UP = 1'b1; PRE = 1'b1; WB = 1'b1;
    BASE = 32'h0000_1000; OFFSET = 32'h0; VALID = 1'b1;
    @(posedge CLK);
    #1 VALID = 1'b0;
    @(negedge CLK);
    check("abort_req_up", {31'b0, DM_REQ}, 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    last_load = '0;
    @(negedge CLK);
    check("abort_req", {31'b0, DM_REQ}, 32'd0);
    check("abort_stall", {31'b0, STALL}, 32'd0);
    check("abort_done", {31'b0, DONE}, 32'd0);
    check("abort_addr", DM_ADDR, 32'd0);
    check("abort_load_data", LOAD_DATA, 32'd0);
    DM_ACK = 1'b1;
    DM_RDATA = 32'h5555_AAAA;
    @(posedge CLK);
    #1 DM_ACK = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("late_ack_done", {31'b0, DONE}, 32'd0);
      check("late_ack_req", {31'b0, DM_REQ}, 32'd0);
      check("late_ack_stall", {31'b0, STALL}, 32'd0);
      check("late_ack_load", LOAD_DATA, 32'd0);
    end

    cur = -1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
